// File: rtl/seven_segment_decoder_if.sv
// Bus between a seven-segment source and the receive-side decoder/checker.
// The master drives the active-low segment bus; the slave (the decoder)
// returns the decoded digit, status flags and event counters.
interface seven_segment_decoder_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       seg_in;
    logic [3:0]       value;
    logic             value_valid;
    logic             update;
    logic             invalid;
    logic             step_err;
    logic [CNT_W-1:0] update_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output seg_in,
        input  value,
        input  value_valid,
        input  update,
        input  invalid,
        input  step_err,
        input  update_count,
        input  err_count
    );

    modport slave (
        input  seg_in,
        output value,
        output value_valid,
        output update,
        output invalid,
        output step_err,
        output update_count,
        output err_count
    );
endinterface

// File: rtl/seven_segment_decoder.sv
// Receive-side seven-segment checker: debounces the active-low segment bus,
// decodes accepted patterns back to a hex digit, and flags illegal glyphs
// and sequence steps other than +1 mod 16.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_EMPTY  | no digit held (after reset or a blank); next digit is "first"
// S_LOCKED | value holds an accepted digit; next change is step-checked
//
// The bus CNT_W must match the CNT_W of the connected interface instance.
module seven_segment_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    seven_segment_decoder_if.slave       bus
);

    typedef enum logic {
        S_EMPTY  = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

    // {legal digit, blank, digit}; all-zero means an illegal code
    function automatic logic [5:0] decode_glyph(input logic [6:0] seg);
        logic [5:0] r;
        case (seg)
            7'h40:   r = {2'b10, 4'h0};
            7'h79:   r = {2'b10, 4'h1};
            7'h24:   r = {2'b10, 4'h2};
            7'h30:   r = {2'b10, 4'h3};
            7'h19:   r = {2'b10, 4'h4};
            7'h12:   r = {2'b10, 4'h5};
            7'h02:   r = {2'b10, 4'h6};
            7'h78:   r = {2'b10, 4'h7};
            7'h00:   r = {2'b10, 4'h8};
            7'h10:   r = {2'b10, 4'h9};
            7'h08:   r = {2'b10, 4'hA};
            7'h03:   r = {2'b10, 4'hB};
            7'h46:   r = {2'b10, 4'hC};
            7'h21:   r = {2'b10, 4'hD};
            7'h06:   r = {2'b10, 4'hE};
            7'h0E:   r = {2'b10, 4'hF};
            7'h7F:   r = {2'b01, 4'h0};
            default: r = 6'b00_0000;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [6:0]       seg_q, seg_d;
    logic [7:0]       stab_cnt_q, stab_cnt_d;
    logic [3:0]       value_q, value_d;
    logic             update_q, update_d;
    logic             invalid_q, invalid_d;
    logic             step_err_q, step_err_d;
    logic [CNT_W-1:0] update_count_q, update_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic [6:0]       seg_now;
    logic             same;
    logic             accept;
    logic [5:0]       glyph;
    logic             is_digit;
    logic             is_blank;
    logic [3:0]       digit;
    logic             err_evt;
    logic             unused_dp;

    // The decimal point carries no digit information
    assign unused_dp = bus.seg_in[7];
    assign seg_now   = bus.seg_in[6:0];
    assign same      = (seg_now == seg_q);
    // Accept on the edge that would take the run length to STABLE_CYCLES
    assign accept    = same && (stab_cnt_q == STAB_LAST);
    assign glyph     = decode_glyph(seg_now);
    assign is_digit  = glyph[5];
    assign is_blank  = glyph[4];
    assign digit     = glyph[3:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: blank empties, a legal digit locks, an illegal code holds
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (is_blank) begin
                state_d = S_EMPTY;
            end else if (is_digit) begin
                state_d = S_LOCKED;
            end
        end
    end

    // Output/datapath next values: stability tracking, decode, pulses, counters
    always_comb begin
        seg_d          = seg_now;
        stab_cnt_d     = stab_cnt_q;
        value_d        = value_q;
        update_d       = 1'b0;
        step_err_d     = 1'b0;
        invalid_d      = invalid_q;
        err_evt        = 1'b0;
        update_count_d = update_count_q;
        err_count_d    = err_count_q;

        if (!same) begin
            stab_cnt_d = 8'd0;
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end

        if (accept) begin
            if (is_digit) begin
                invalid_d = 1'b0;
                if (state_q == S_EMPTY) begin
                    value_d  = digit;
                    update_d = 1'b1;
                end else if (digit != value_q) begin
                    value_d    = digit;
                    update_d   = 1'b1;
                    step_err_d = (digit != 4'(value_q + 4'd1));
                end
            end else if (is_blank) begin
                invalid_d = 1'b0;
            end else begin
                invalid_d = 1'b1;
                err_evt   = 1'b1;
            end
        end

        if (step_err_d) begin
            err_evt = 1'b1;
        end

        if (update_d && (update_count_q != {CNT_W{1'b1}})) begin
            update_count_d = update_count_q + 1'b1;
        end
        if (err_evt && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q          <= 7'h7F;
            stab_cnt_q     <= 8'd0;
            value_q        <= 4'h0;
            update_q       <= 1'b0;
            step_err_q     <= 1'b0;
            invalid_q      <= 1'b0;
            update_count_q <= '0;
            err_count_q    <= '0;
        end else begin
            seg_q          <= seg_d;
            stab_cnt_q     <= stab_cnt_d;
            value_q        <= value_d;
            update_q       <= update_d;
            step_err_q     <= step_err_d;
            invalid_q      <= invalid_d;
            update_count_q <= update_count_d;
            err_count_q    <= err_count_d;
        end
    end

    assign bus.value        = value_q;
    assign bus.value_valid  = (state_q == S_LOCKED);
    assign bus.update       = update_q;
    assign bus.step_err     = step_err_q;
    assign bus.invalid      = invalid_q;
    assign bus.update_count = update_count_q;
    assign bus.err_count    = err_count_q;

endmodule

// File: doc/seven_segment_decoder.md
Name: seven_segment_decoder

Overview:
- Receive-side counterpart of the hex seven-segment driver: samples an active-low 8-bit segment bus, waits for the pattern to be stable, and decodes it back to a 4-bit hex value.
- Flags patterns that are not legal glyphs, and flags sequence steps other than +1 mod 16.
- Used as an on-chip loopback checker / bench monitor for display outputs.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (legal range 2..255).
- CNT_W, 16, width of the saturating event counters.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous reset, active-high.
- seg_in  input  8  segment bus, active-low; bit0=a ... bit6=g; bit7 (DP) ignored.
- value  output  4  last accepted legal digit.
- value_valid  output  1  level: value holds a digit accepted since reset or since the last blank.
- update  output  1  one-cycle pulse: value changed, or first digit accepted.
- invalid  output  1  level: currently accepted pattern is not a legal glyph.
- step_err  output  1  one-cycle pulse, coincident with update: new value != (old value + 1) mod 16.
- update_count  output  CNT_W  number of update pulses, saturating.
- err_count  output  CNT_W  invalid acceptances plus step_err pulses, saturating.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0; FSM goes to EMPTY.
  - Internal sample register seg_q is set to 7'h7F; stab_cnt is set to 0.
  - Reset asserted mid-operation discards any pattern still settling.
- Sampling and stability:
  - seg_q <= seg_in[6:0] on every edge.
  - If seg_in[6:0] != seg_q: stab_cnt <= 0.
  - Otherwise stab_cnt increments, saturating at STABLE_CYCLES.
  - Acceptance happens on the edge where stab_cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES, exactly once per stable run.
  - Timing: let E0 be the first edge that samples a new pattern. The pattern is accepted at edge E(STABLE_CYCLES), and the registered outputs reflect it in the following cycle.
  - A glitch shorter than STABLE_CYCLES+1 edges is never accepted.
- Legal glyph table (seg_in[6:0], active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, B=03, C=46, D=21, E=06, F=0E
  - Blank = 7F. Every other code is invalid.
- FSM states: EMPTY (value_valid=0) and LOCKED (value_valid=1).
- Accept legal digit d:
  - In EMPTY: value<=d, update=1, step_err=0, go to LOCKED.
  - In LOCKED with d != value: value<=d, update=1; step_err=1 if d != value+1 (4-bit wrap, so F->0 is legal).
  - In LOCKED with d == value: no pulse.
  - In all cases invalid<=0.
- Accept blank: invalid<=0, go to EMPTY, value holds its old contents, no pulses, no error. The next accepted digit is treated as "first", so there is no step check across a blank.
- Accept invalid code: invalid<=1, err_count increments once. value, value_valid and state are unchanged, and no update is generated. invalid stays high until the next acceptance.
- Counters:
  - update_count increments on each update pulse.
  - err_count increments on an invalid acceptance or a step_err pulse; these are mutually exclusive within a cycle.
  - Both counters saturate at all-ones and never wrap.
- update, step_err and invalid are registered; there are no combinational paths from seg_in to outputs.

Test Plan:
- Reset, then hold seg_in=8'hC0 (0) with STABLE_CYCLES=4 -> update pulses once in the cycle after E4; value=0, value_valid=1, step_err=0, update_count=1.
- Drive the sequence 0,1,...,F,0, each held 10 cycles -> 17 update pulses, no step_err, err_count=0; the F->0 wrap is not an error.
- From 3 (30) jump to 7 (78) -> update=1 and step_err=1 in the same cycle; value=7, err_count=1.
- From 5, hold 7'h7F... wait, from 5 drive 7'h55 (illegal) for 10 cycles, then return to 5 -> invalid=1 after acceptance, err_count+1, value stays 5, no update. After returning to 5: invalid=0, still no update.
- 3-cycle glitch to 79 while 2 is displayed -> no acceptance, no pulses; 6-cycle glitch -> update to 1 with step_err.
- Blank (7F) while at 9, then 4 -> value_valid drops to 0; on 4, update=1 with step_err=0. Asserting reset mid-settle clears all outputs on the next edge.
